// File: rtl/top.sv
// Ultrasonic parking-distance indicator: periodic HC-SR04 trigger, echo-width
// measurement in whole centimetres, and RGB LED / buzzer distance bands.
`timescale 1ns/1ps
module top #(
  parameter int unsigned TRIG_CYCLES   = 500,
  parameter int unsigned MEAS_PERIOD   = 3_000_000,
  parameter int unsigned CYCLES_PER_CM = 2900,
  parameter int unsigned ECHO_TIMEOUT  = 1_500_000,
  parameter int unsigned BUZZ_HALF     = 12500,
  parameter int unsigned NEAR_CM       = 10,
  parameter int unsigned MID_CM        = 30,
  parameter int unsigned FAR_CM        = 50
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic echo,
  output logic trig,
  output logic buzzer_out,
  output logic red_led,
  output logic green_led,
  output logic blue_led
);

  localparam int PW = $clog2(MEAS_PERIOD);
  localparam int TW = $clog2(TRIG_CYCLES + 1);
  localparam int EW = $clog2(ECHO_TIMEOUT + 1);
  localparam int SW = $clog2(CYCLES_PER_CM + 1);
  localparam int BW = $clog2(BUZZ_HALF + 1);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(MEAS_PERIOD - 1);
  localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
  localparam logic [EW-1:0] TMO_LAST    = EW'(ECHO_TIMEOUT - 1);
  localparam logic [EW-1:0] TMO_MAX     = EW'(ECHO_TIMEOUT);
  localparam logic [SW-1:0] SUB_LAST    = SW'(CYCLES_PER_CM - 1);
  localparam logic [BW-1:0] BUZZ_LAST   = BW'(BUZZ_HALF - 1);
  localparam logic [7:0]    NEAR_D      = 8'(NEAR_CM);
  localparam logic [7:0]    MID_D       = 8'(MID_CM);
  localparam logic [7:0]    FAR_D       = 8'(FAR_CM);
  localparam logic [7:0]    DIST_FAR    = 8'hFF;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, UPDATE} state_t;

  state_t          state, state_next;
  logic            echo_meta, echo_s;
  logic [PW-1:0]   period_cnt;
  logic [TW-1:0]   trig_cnt;
  logic [EW-1:0]   tmo_cnt;
  logic [SW-1:0]   sub_cnt;
  logic [7:0]      cm_cnt;
  logic [7:0]      distance, dist_val, dist_next;
  logic            dist_load;
  logic            start;
  logic            near_band;
  logic [BW-1:0]   buzz_cnt;

  assign start = (period_cnt == '0);

  // Two-flop synchronizer: echo comes straight off a pin, unrelated to clk50.
  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig       <= 1'b0;
      period_cnt <= '0;
      trig_cnt   <= '0;
    end else begin
      state      <= state_next;
      trig       <= (state_next == TRIG);
      period_cnt <= (period_cnt == PERIOD_LAST) ? '0 : period_cnt + 1'b1;
      trig_cnt   <= (state == TRIG && !start) ? trig_cnt + 1'b1 : '0;
    end
  end

  // NOTE: every output of this block gets a default first; a missed path would infer a latch.
  always_comb begin
    state_next = state;
    dist_load  = 1'b0;
    dist_val   = DIST_FAR;
    case (state)
      IDLE:      if (start) state_next = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) state_next = WAIT_ECHO;
      WAIT_ECHO: begin
        if (echo_s) begin
          state_next = MEASURE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = UPDATE;
          dist_load  = 1'b1;
        end
      end
      MEASURE: begin
        if (!echo_s) begin
          state_next = UPDATE;
          dist_load  = 1'b1;
          dist_val   = cm_cnt;
        end else if (tmo_cnt >= TMO_MAX) begin
          state_next = UPDATE;
          dist_load  = 1'b1;
        end
      end
      UPDATE:    state_next = start ? TRIG : IDLE;
      default:   state_next = IDLE;
    endcase
    // A period wrap mid-measurement reports "out of range" and retriggers at once.
    if (start && (state inside {TRIG, WAIT_ECHO, MEASURE})) begin
      state_next = TRIG;
      dist_load  = 1'b1;
      dist_val   = DIST_FAR;
    end
    dist_next = dist_load ? dist_val : distance;
    near_band = (dist_next < NEAR_D);
  end

  // tmo_cnt doubles as the rise timeout in WAIT_ECHO and the high-time limit in MEASURE;
  // the rising clock itself is the first counted high clock.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      sub_cnt <= '0;
      cm_cnt  <= '0;
    end else begin
      case (state)
        WAIT_ECHO: tmo_cnt <= echo_s ? EW'(1) : tmo_cnt + 1'b1;
        MEASURE:   tmo_cnt <= tmo_cnt + 1'b1;
        default:   tmo_cnt <= '0;
      endcase
      if (!(state inside {WAIT_ECHO, MEASURE})) begin
        sub_cnt <= '0;
        cm_cnt  <= '0;
      end else if (echo_s) begin
        if (sub_cnt == SUB_LAST) begin
          sub_cnt <= '0;
          if (cm_cnt != 8'hFF) cm_cnt <= cm_cnt + 8'd1;
        end else begin
          sub_cnt <= sub_cnt + 1'b1;
        end
      end
    end
  end

  // Bands are reloaded from dist_next every clock, so they only move when a result lands.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      distance  <= DIST_FAR;
      red_led   <= 1'b0;
      blue_led  <= 1'b0;
      green_led <= 1'b0;
    end else begin
      distance  <= dist_next;
      red_led   <= near_band;
      blue_led  <= (dist_next >= NEAR_D) && (dist_next < MID_D);
      green_led <= (dist_next >= MID_D) && (dist_next < FAR_D);
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      buzz_cnt   <= '0;
      buzzer_out <= 1'b0;
    end else if (!near_band) begin
      buzz_cnt   <= '0;
      buzzer_out <= 1'b0;
    end else if (buzz_cnt == BUZZ_LAST) begin
      buzz_cnt   <= '0;
      buzzer_out <= ~buzzer_out;
    end else begin
      buzz_cnt   <= buzz_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the parking-distance indicator: table of echo widths
// with a scoreboard of expected LED bands, plus hand-written timeout/reset sequences.
`timescale 1ns/1ps
module tb_top;

  localparam int CPC    = 10;
  localparam int TRIG_C = 5;
  localparam int PERIOD = 2000;
  localparam int TMO    = 1000;
  localparam int BUZZ   = 4;

  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  logic echo  = 1'b0;
  logic trig, buzzer_out, red_led, green_led, blue_led;

  top #(
    .TRIG_CYCLES  (TRIG_C),
    .MEAS_PERIOD  (PERIOD),
    .CYCLES_PER_CM(CPC),
    .ECHO_TIMEOUT (TMO),
    .BUZZ_HALF    (BUZZ)
  ) dut (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .echo      (echo),
    .trig      (trig),
    .buzzer_out(buzzer_out),
    .red_led   (red_led),
    .green_led (green_led),
    .blue_led  (blue_led)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    int    width;
    logic  red;
    logic  blue;
    logic  green;
    string name;
  } vec_t;

  typedef struct {
    logic  red;
    logic  blue;
    logic  green;
    string name;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  exp_t       sb[$];
  logic [2:0] last_leds = 3'b000;   // {red, blue, green} currently expected

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int w, input logic r, input logic b, input logic g,
                              input string n);
    vec_t v;
    v.width = w; v.red = r; v.blue = b; v.green = g; v.name = n;
    return v;
  endfunction

  always @(posedge clk50) cyc++;

  // Trigger monitor: width of every pulse and spacing of consecutive rising edges.
  int   prev_rise = -1;
  int   trig_len  = 0;
  logic trig_prev = 1'b0;
  always @(negedge clk50) begin
    if (!rst_n) begin
      prev_rise = -1;
      trig_len  = 0;
      trig_prev = 1'b0;
    end else begin
      if (trig && !trig_prev) begin
        if (prev_rise >= 0) check("trig_period", cyc - prev_rise, PERIOD);
        prev_rise = cyc;
        trig_len  = 0;
      end
      if (trig) trig_len++;
      if (!trig && trig_prev) check("trig_width", trig_len, TRIG_C);
      trig_prev = trig;
    end
  end

  task automatic wait_trig_cycle();
    int n;
    n = 0;
    while (trig !== 1'b1 && n < PERIOD + 100) begin
      @(negedge clk50);
      n++;
    end
    if (trig !== 1'b1) check("trig_rise_wait", trig, 1);
    n = 0;
    while (trig !== 1'b0 && n < 4 * TRIG_C) begin
      @(negedge clk50);
      n++;
    end
    if (trig !== 1'b0) check("trig_fall_wait", trig, 0);
  endtask

  task automatic pulse_echo(input int width);
    echo = 1'b1;
    repeat (width) @(negedge clk50);
    echo = 1'b0;
  endtask

  task automatic measure(input vec_t v, input bit latency);
    exp_t e, got;
    wait_trig_cycle();
    repeat (3) @(negedge clk50);
    pulse_echo(v.width);
    e.red = v.red; e.blue = v.blue; e.green = v.green; e.name = v.name;
    sb.push_back(e);
    repeat (2) @(negedge clk50);
    if (latency) check({v.name, "_hold"}, {red_led, blue_led, green_led}, last_leds);
    @(negedge clk50);
    got = sb.pop_front();
    check({got.name, "_leds"}, {red_led, blue_led, green_led}, {got.red, got.blue, got.green});
    if (!got.red) check({got.name, "_buzz_off"}, buzzer_out, 0);
    last_leds = {got.red, got.blue, got.green};
  endtask

  task automatic check_buzzer();
    int   n;
    logic lvl;
    n = 0;
    while (buzzer_out !== 1'b1 && n < 2 * BUZZ) begin
      @(negedge clk50);
      n++;
    end
    check("buzz_start", buzzer_out, 1);
    for (int k = 0; k < 2; k++) begin
      lvl = buzzer_out;
      n   = 0;
      while (buzzer_out === lvl && n < 4 * BUZZ) begin
        @(negedge clk50);
        n++;
      end
      check("buzz_half_period", n, BUZZ);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = mk(50,  1'b1, 1'b0, 1'b0, "near_50");
    tbl[1] = mk(240, 1'b0, 1'b1, 1'b0, "mid_240");
    tbl[2] = mk(310, 1'b0, 1'b0, 1'b1, "far_310");
    tbl[3] = mk(520, 1'b0, 1'b0, 1'b0, "off_520");
    tbl[4] = mk(99,  1'b1, 1'b0, 1'b0, "edge_99");
    tbl[5] = mk(100, 1'b0, 1'b1, 1'b0, "edge_100");
    tbl[6] = mk(299, 1'b0, 1'b1, 1'b0, "edge_299");
    tbl[7] = mk(300, 1'b0, 1'b0, 1'b1, "edge_300");
    tbl[8] = mk(499, 1'b0, 1'b0, 1'b1, "edge_499");
    tbl[9] = mk(500, 1'b0, 1'b0, 1'b0, "edge_500");

    rst_n = 1'b0;
    echo  = 1'b0;
    repeat (3) @(negedge clk50);
    check("reset_outputs", {trig, buzzer_out, red_led, green_led, blue_led}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk50);
    check("first_trig", trig, 1);

    for (int i = 0; i < 10; i++) begin
      measure(tbl[i], 1'b1);
      if (tbl[i].red) check_buzzer();
    end

    // Echo while idle must not disturb the displayed band.
    repeat (5) @(negedge clk50);
    pulse_echo(50);
    repeat (10) @(negedge clk50);
    check("spurious_idle", {red_led, blue_led, green_led}, last_leds);

    // No echo at all: band holds until the rise timeout, then goes dark.
    measure(mk(310, 1'b0, 1'b0, 1'b1, "far_pre_noecho"), 1'b1);
    wait_trig_cycle();
    repeat (995) @(negedge clk50);
    check("noecho_hold", {red_led, blue_led, green_led}, last_leds);
    repeat (7) @(negedge clk50);
    check("noecho_timeout", {red_led, blue_led, green_led, buzzer_out}, 4'b0000);
    last_leds = 3'b000;

    // Echo stuck high past the limit reads as out of range; next period is normal.
    measure(mk(50,   1'b1, 1'b0, 1'b0, "near_pre_long"), 1'b1);
    measure(mk(1200, 1'b0, 1'b0, 1'b0, "long_echo"), 1'b0);
    measure(mk(240,  1'b0, 1'b1, 1'b0, "mid_after_long"), 1'b1);

    // Asynchronous reset in the middle of a measurement.
    measure(mk(50, 1'b1, 1'b0, 1'b0, "near_pre_reset"), 1'b1);
    wait_trig_cycle();
    repeat (3) @(negedge clk50);
    echo = 1'b1;
    repeat (20) @(negedge clk50);
    check("red_before_reset", red_led, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {trig, buzzer_out, red_led, green_led, blue_led}, 5'b0);
    echo = 1'b0;
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    last_leds = 3'b000;
    measure(mk(240, 1'b0, 1'b1, 1'b0, "mid_after_reset"), 1'b1);
    wait_trig_cycle();

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
